// File: rtl/revive_mem_stage.sv
// Memory-access stage: ALU result passthrough or single-outstanding bus load/store.
// Latency: non-mem/misaligned wb at N+1; bus access wb at N+3 minimum (+1 per gnt/rvalid wait).
// Backpressure: ex_ready low while a bus transaction is in REQ or RESP; no timeout.
module revive_mem_stage #(
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [W_DATA-1:0] ex_result,
  input  logic [W_DATA-1:0] ex_store_data,
  input  logic              ex_mem_en,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_unsigned,
  input  logic [4:0]        ex_rd,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [W_DATA-1:0] bus_addr,
  output logic              bus_write,
  output logic [1:0]        bus_size,
  output logic [W_DATA-1:0] bus_wdata,
  input  logic              bus_rvalid,
  input  logic [W_DATA-1:0] bus_rdata,
  input  logic              bus_err,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [W_DATA-1:0] wb_data,
  output logic              wb_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t            state;
  state_t            state_next;
  logic              misaligned;
  logic              alu_accept;
  logic              fault_accept;
  logic              bus_accept;
  logic              resp_done;
  logic              unsigned_q;
  logic [4:0]        rd_q;
  logic [W_DATA-1:0] wdata_lanes;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [W_DATA-1:0] load_data;

  // Alignment check on the effective address; size 3 is reserved and always faults
  always_comb begin
    misaligned = 1'b0;
    case (ex_mem_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = ex_result[0];
      2'd2:    misaligned = |ex_result[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign alu_accept   = (state == IDLE) && ex_valid && !ex_mem_en;
  assign fault_accept = (state == IDLE) && ex_valid && ex_mem_en && misaligned;
  assign bus_accept   = (state == IDLE) && ex_valid && ex_mem_en && !misaligned;
  assign resp_done    = (state == RESP) && bus_rvalid;

  // State register; async reset abandons any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: gnt only matters in REQ, rvalid only in RESP
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus_accept) state_next = REQ;
      REQ:     if (bus_gnt)    state_next = RESP;
      RESP:    if (bus_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state only, so reset drops bus_req without waiting for a clock
  always_comb begin
    ex_ready = (state == IDLE);
    bus_req  = (state == REQ);
  end

  // Store data replicated across every lane the transfer size can touch
  always_comb begin
    wdata_lanes = ex_store_data;
    case (ex_mem_size)
      2'd0:    wdata_lanes = {4{ex_store_data[7:0]}};
      2'd1:    wdata_lanes = {2{ex_store_data[15:0]}};
      default: wdata_lanes = ex_store_data;
    endcase
  end

  // Load lane extraction and sign/zero extension from the latched address and size
  always_comb begin
    lane_b = bus_rdata[7:0];
    case (bus_addr[1:0])
      2'd0: lane_b = bus_rdata[7:0];
      2'd1: lane_b = bus_rdata[15:8];
      2'd2: lane_b = bus_rdata[23:16];
      2'd3: lane_b = bus_rdata[31:24];
      default: lane_b = bus_rdata[7:0];
    endcase
    lane_h    = bus_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    load_data = bus_rdata;
    case (bus_size)
      2'd0:    load_data = {{24{lane_b[7]  & ~unsigned_q}}, lane_b};
      2'd1:    load_data = {{16{lane_h[15] & ~unsigned_q}}, lane_h};
      default: load_data = bus_rdata;
    endcase
  end

  // Request latch: address-phase fields stay frozen from accept until the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_addr   <= '0;
      bus_size   <= 2'd0;
      bus_write  <= 1'b0;
      bus_wdata  <= '0;
      unsigned_q <= 1'b0;
      rd_q       <= 5'd0;
    end else if (bus_accept) begin
      bus_addr   <= ex_result;
      bus_size   <= ex_mem_size;
      bus_write  <= ex_mem_write;
      bus_wdata  <= wdata_lanes;
      unsigned_q <= ex_mem_unsigned;
      rd_q       <= ex_rd;
    end
  end

  // Writeback beat: wb_valid pulses one cycle, the other wb fields hold until the next beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= '0;
      wb_err   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (alu_accept) begin
        wb_valid <= 1'b1;
        wb_rd    <= ex_rd;
        wb_data  <= ex_result;
        wb_err   <= 1'b0;
      end else if (fault_accept) begin
        wb_valid <= 1'b1;
        wb_rd    <= 5'd0;
        wb_data  <= ex_result;
        wb_err   <= 1'b1;
      end else if (resp_done) begin
        wb_valid <= 1'b1;
        wb_rd    <= (!bus_write && bus_err) ? 5'd0 : rd_q;
        wb_data  <= (bus_write || bus_err) ? '0 : load_data;
        wb_err   <= bus_err;
      end
    end
  end

endmodule

// File: tb/tb_revive_mem_stage.sv
// Directed bench for revive_mem_stage: ALU passthrough, loads, stores, faults, reset abandon.
// Inputs are driven and outputs sampled 1ns after each rising edge.
// Bus responses are driven by the bench with fixed, hand-placed gnt/rvalid timing.
module tb_revive_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_result = '0;
  logic [31:0] ex_store_data = '0;
  logic        ex_mem_en = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [1:0]  ex_mem_size = 2'd0;
  logic        ex_mem_unsigned = 1'b0;
  logic [4:0]  ex_rd = 5'd0;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic [31:0] bus_addr;
  logic        bus_write;
  logic [1:0]  bus_size;
  logic [31:0] bus_wdata;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;

  int tests_run = 0;
  int tests_failed = 0;

  revive_mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_mem_en(ex_mem_en), .ex_mem_write(ex_mem_write),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned), .ex_rd(ex_rd),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_size(bus_size), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic mem, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] res,
                         input logic [31:0] sd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_mem_en = mem; ex_mem_write = wr; ex_mem_size = sz;
    ex_mem_unsigned = uns; ex_result = res; ex_store_data = sd; ex_rd = rd;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    tests_run++;
    if ({ex_ready, bus_req, wb_valid, wb_err, wb_rd, wb_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0}) begin
      tests_failed++;
      $display("FAIL reset_wb: rdy/req/v/err/rd/data got %b %b %b %b %0d %h want 1 0 0 0 0 00000000",
               ex_ready, bus_req, wb_valid, wb_err, wb_rd, wb_data);
    end
    tests_run++;
    if ({bus_addr, bus_wdata, bus_size, bus_write} !== {32'd0, 32'd0, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_bus: addr %h wdata %h size %0d write %b want all zero",
               bus_addr, bus_wdata, bus_size, bus_write);
    end
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_alu_back_to_back;
    present(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_1234, 32'd0, 5'd5);
    tests_run++;
    if (ex_ready !== 1'b1) begin
      tests_failed++; $display("FAIL alu_ready0: got %b want 1", ex_ready);
    end
    tick;
    tests_run++;
    if ({wb_valid, wb_err, wb_rd, wb_data, ex_ready} !== {1'b1, 1'b0, 5'd5, 32'h0000_1234, 1'b1}) begin
      tests_failed++;
      $display("FAIL alu_add: v/err/rd/data/rdy got %b %b %0d %h %b want 1 0 5 00001234 1",
               wb_valid, wb_err, wb_rd, wb_data, ex_ready);
    end
    present(1'b0, 1'b0, 2'd2, 1'b0, 32'hFFFF_0000, 32'd0, 5'd6);
    tick;
    ex_valid = 1'b0;
    tests_run++;
    if ({wb_valid, wb_err, wb_rd, wb_data, ex_ready} !== {1'b1, 1'b0, 5'd6, 32'hFFFF_0000, 1'b1}) begin
      tests_failed++;
      $display("FAIL alu_xor: v/err/rd/data/rdy got %b %b %0d %h %b want 1 0 6 ffff0000 1",
               wb_valid, wb_err, wb_rd, wb_data, ex_ready);
    end
    tick;
    tests_run++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b0, 5'd6, 32'hFFFF_0000}) begin
      tests_failed++;
      $display("FAIL alu_hold: v/rd/data got %b %0d %h want 0 6 ffff0000", wb_valid, wb_rd, wb_data);
    end
  endtask

  task automatic test_lb(input logic uns, input logic [31:0] exp);
    present(1'b1, 1'b0, 2'd0, uns, 32'h0000_0103, 32'd0, 5'd7);
    bus_gnt = 1'b1;
    tick;                                   // N+1: REQ
    ex_valid = 1'b0;
    tests_run++;
    if ({bus_req, bus_addr, bus_size, bus_write, ex_ready, wb_valid} !==
        {1'b1, 32'h0000_0103, 2'd0, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL lb_req: req/addr/size/wr/rdy/wbv got %b %h %0d %b %b %b want 1 00000103 0 0 0 0",
               bus_req, bus_addr, bus_size, bus_write, ex_ready, wb_valid);
    end
    tick;                                   // N+2: RESP
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h80AB_CDEF;
    tests_run++;
    if ({bus_req, ex_ready, wb_valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL lb_resp: req/rdy/wbv got %b %b %b want 0 0 0", bus_req, ex_ready, wb_valid);
    end
    tick;                                   // N+3: writeback
    bus_rvalid = 1'b0;
    tests_run++;
    if ({wb_valid, wb_err, wb_rd, wb_data, ex_ready} !== {1'b1, 1'b0, 5'd7, exp, 1'b1}) begin
      tests_failed++;
      $display("FAIL lb_wb(uns=%0d): v/err/rd/data/rdy got %b %b %0d %h %b want 1 0 7 %h 1",
               uns, wb_valid, wb_err, wb_rd, wb_data, ex_ready, exp);
    end
    tick;
    tests_run++;
    if (wb_valid !== 1'b0) begin
      tests_failed++; $display("FAIL lb_single_beat: wb_valid got %b want 0", wb_valid);
    end
  endtask

  task automatic test_lh_wait;
    present(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'd0, 5'd8);
    tick;
    ex_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if ({bus_req, bus_addr, bus_size, ex_ready} !== {1'b1, 32'h0000_0202, 2'd1, 1'b0}) begin
        tests_failed++;
        $display("FAIL lh_req_hold[%0d]: req/addr/size/rdy got %b %h %0d %b want 1 00000202 1 0",
                 i, bus_req, bus_addr, bus_size, ex_ready);
      end
      bus_gnt = (i == 3);
      tick;
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h8001_7FFF;
    tests_run++;
    if ({bus_req, ex_ready} !== 2'b00) begin
      tests_failed++; $display("FAIL lh_resp: req/rdy got %b %b want 0 0", bus_req, ex_ready);
    end
    tick;
    bus_rvalid = 1'b0;
    tests_run++;
    if ({wb_valid, wb_err, wb_rd, wb_data} !== {1'b1, 1'b0, 5'd8, 32'hFFFF_8001}) begin
      tests_failed++;
      $display("FAIL lh_wb: v/err/rd/data got %b %b %0d %h want 1 0 8 ffff8001",
               wb_valid, wb_err, wb_rd, wb_data);
    end
  endtask

  task automatic test_store(input logic [31:0] addr, input logic [31:0] d,
                            input logic [1:0] sz, input logic [31:0] exp_wdata);
    present(1'b1, 1'b1, sz, 1'b0, addr, d, 5'd0);
    tick;
    ex_valid = 1'b0;
    tests_run++;
    if ({bus_req, bus_write, bus_addr, bus_size, bus_wdata} !== {1'b1, 1'b1, addr, sz, exp_wdata}) begin
      tests_failed++;
      $display("FAIL store_req(sz=%0d): req/wr/addr/size/wdata got %b %b %h %0d %h want 1 1 %h %0d %h",
               sz, bus_req, bus_write, bus_addr, bus_size, bus_wdata, addr, sz, exp_wdata);
    end
    bus_gnt = 1'b1;
    tick;
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick;
    bus_rvalid = 1'b0;
    tests_run++;
    if ({wb_valid, wb_err, wb_rd, wb_data} !== {1'b1, 1'b0, 5'd0, 32'd0}) begin
      tests_failed++;
      $display("FAIL store_ack(sz=%0d): v/err/rd/data got %b %b %0d %h want 1 0 0 00000000",
               sz, wb_valid, wb_err, wb_rd, wb_data);
    end
  endtask

  task automatic test_misaligned_back_to_back;
    present(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'd0, 5'd9);
    tick;
    tests_run++;
    if ({bus_req, wb_valid, wb_err, wb_rd, wb_data, ex_ready} !== {1'b0, 1'b1, 1'b1, 5'd0, 32'h6, 1'b1}) begin
      tests_failed++;
      $display("FAIL mis_lw: req/v/err/rd/data/rdy got %b %b %b %0d %h %b want 0 1 1 0 00000006 1",
               bus_req, wb_valid, wb_err, wb_rd, wb_data, ex_ready);
    end
    present(1'b1, 1'b1, 2'd1, 1'b0, 32'h0000_0011, 32'h5555_5555, 5'd0);
    tick;
    tests_run++;
    if ({bus_req, wb_valid, wb_err, wb_data} !== {1'b0, 1'b1, 1'b1, 32'h11}) begin
      tests_failed++;
      $display("FAIL mis_sh: req/v/err/data got %b %b %b %h want 0 1 1 00000011",
               bus_req, wb_valid, wb_err, wb_data);
    end
    present(1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0020, 32'd0, 5'd4);
    tick;
    ex_valid = 1'b0;
    tests_run++;
    if ({bus_req, wb_valid, wb_err, wb_rd, wb_data} !== {1'b0, 1'b1, 1'b1, 5'd0, 32'h20}) begin
      tests_failed++;
      $display("FAIL mis_size3: req/v/err/rd/data got %b %b %b %0d %h want 0 1 1 0 00000020",
               bus_req, wb_valid, wb_err, wb_rd, wb_data);
    end
    tick;
    tests_run++;
    if ({bus_req, wb_valid} !== 2'b00) begin
      tests_failed++; $display("FAIL mis_idle: req/v got %b %b want 0 0", bus_req, wb_valid);
    end
  endtask

  task automatic test_bus_err;
    present(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'd0, 5'd10);
    bus_gnt = 1'b1;
    tick;
    ex_valid = 1'b0;
    tick;
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_err = 1'b1; bus_rdata = 32'h1234_5678;
    tick;
    bus_rvalid = 1'b0; bus_err = 1'b0;
    tests_run++;
    if ({wb_valid, wb_err, wb_rd, wb_data} !== {1'b1, 1'b1, 5'd0, 32'd0}) begin
      tests_failed++;
      $display("FAIL lw_bus_err: v/err/rd/data got %b %b %0d %h want 1 1 0 00000000",
               wb_valid, wb_err, wb_rd, wb_data);
    end
  endtask

  task automatic test_reset_mid;
    // Abandon in REQ: bus_req must drop without a clock edge
    present(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 5'd3);
    tick;
    ex_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bus_req, ex_ready} !== 2'b01) begin
      tests_failed++; $display("FAIL rst_in_req: req/rdy got %b %b want 0 1", bus_req, ex_ready);
    end
    tick;
    rst = 1'b0;
    tick;
    // Abandon in RESP of a load, then a late rvalid must not produce a beat
    present(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'd0, 5'd3);
    bus_gnt = 1'b1;
    tick;
    ex_valid = 1'b0;
    tick;
    bus_gnt = 1'b0;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bus_req, wb_valid, ex_ready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL rst_in_resp: req/v/rdy got %b %b %b want 0 0 1", bus_req, wb_valid, ex_ready);
    end
    tick;
    rst = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      tick;
      tests_run++;
      if ({wb_valid, bus_req, ex_ready} !== 3'b001) begin
        tests_failed++;
        $display("FAIL late_rvalid[%0d]: v/req/rdy got %b %b %b want 0 0 1", i, wb_valid, bus_req, ex_ready);
      end
    end
    bus_rvalid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_alu_back_to_back;
    test_lb(1'b0, 32'hFFFF_FF80);
    test_lb(1'b1, 32'h0000_0080);
    test_lh_wait;
    test_store(32'h0000_0003, 32'h1234_56A5, 2'd0, 32'hA5A5_A5A5);
    test_store(32'h0000_0002, 32'h1234_ABCD, 2'd1, 32'hABCD_ABCD);
    test_store(32'h0000_0010, 32'h1234_ABCD, 2'd2, 32'h1234_ABCD);
    test_misaligned_back_to_back;
    test_bus_err;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
